// File: rtl/operator_port.sv
// Operator-side endpoint of the calculator link: takes one operand from the host,
// drives it to the calculator, and returns the result (or a timeout error) to the host.
module operator_port #(
    parameter int unsigned LATENCY = 1,   // 1..15
    parameter int unsigned TIMEOUT = 16   // 2..255
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] o2cData,
    input  logic [7:0] c2oData,
    input  logic       operation_enable,
    output logic       busy,
    output logic [7:0] txn_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LAST  = 4'(LATENCY - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] lat_q, lat_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] o2c_d;
    logic [7:0] rsp_data_d;
    logic       rsp_err_d;
    logic [7:0] txn_d;

    always_comb begin
        // NOTE: every variable gets a hold-value default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        lat_d      = lat_q;
        wait_d     = wait_q;
        o2c_d      = o2cData;
        rsp_data_d = rsp_data;
        rsp_err_d  = rsp_err;
        txn_d      = txn_count;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    o2c_d   = cmd_data;
                    wait_d  = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (operation_enable) begin
                    lat_d   = '0;
                    state_d = WAIT;
                end else if (wait_q == WAIT_LAST) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 8'h00;
                    state_d    = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WAIT: begin
                // A dropped enable restarts the whole latency window from ARM.
                if (!operation_enable) begin
                    wait_d  = '0;
                    state_d = ARM;
                end else if (lat_q == LAT_LAST) begin
                    rsp_data_d = c2oData;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    if (!rsp_err) txn_d = txn_count + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            wait_q    <= '0;
            o2cData   <= 8'h00;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
            txn_count <= 8'h00;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            wait_q    <= wait_d;
            o2cData   <= o2c_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            txn_count <= txn_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

    // Response payload must not move while the host is stalling.
    property p_rsp_stable;
        @(posedge clk_100MHz) disable iff (!rst_n)
            (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_err));
    endproperty
    a_rsp_stable: assert property (p_rsp_stable);

    property p_no_overlap;
        @(posedge clk_100MHz) disable iff (!rst_n) !(cmd_ready && busy);
    endproperty
    a_no_overlap: assert property (p_no_overlap);

endmodule

// File: tb/tb_operator_port.sv
// Directed self-checking bench for operator_port: vector table for single transactions,
// hand-written sequences for enable toggling, latency restart, counter wrap and reset.
module tb_operator_port;

    logic       clk = 1'b0;
    logic       rst_n;

    // LATENCY=1 instance
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, en, busy;
    logic [7:0] cmd_data, rsp_data, o2c, c2o, txn;

    // LATENCY=3 instance
    logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_err3, en3, busy3;
    logic [7:0] cmd_data3, rsp_data3, o2c3, c2o3, txn3;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] data;
        logic       en;
        int         hold;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_cycles;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    // Calculator model: one register from operand to result.
    always @(posedge clk) begin
        c2o  <= o2c;
        c2o3 <= o2c3;
    end

    operator_port #(.LATENCY(1), .TIMEOUT(16)) dut (
        .clk_100MHz(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .o2cData(o2c), .c2oData(c2o), .operation_enable(en),
        .busy(busy), .txn_count(txn)
    );

    operator_port #(.LATENCY(3), .TIMEOUT(16)) dut3 (
        .clk_100MHz(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_data(cmd_data3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_err(rsp_err3),
        .o2cData(o2c3), .c2oData(c2o3), .operation_enable(en3),
        .busy(busy3), .txn_count(txn3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One transaction on the LATENCY=1 instance, driven and sampled on falling edges.
    task automatic run_vec(input vec_t v, input logic [7:0] exp_txn);
        int k;
        bit ready_seen;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);
        cmd_data  = v.data;
        cmd_valid = 1'b1;
        en        = v.en;
        rsp_ready = (v.hold == 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("o2c_after_accept", o2c, v.data);
        k = 0;
        ready_seen = 1'b0;
        while (!rsp_valid && k < 100) begin
            if (cmd_ready) ready_seen = 1'b1;
            @(negedge clk);
            k++;
        end
        check("cmd_ready_low_in_txn", ready_seen, 0);
        check("rsp_latency", k, v.exp_cycles);
        check("rsp_data", rsp_data, v.exp_data);
        check("rsp_err", rsp_err, v.exp_err);
        if (v.hold > 0) begin
            cmd_valid = 1'b1;
            cmd_data  = ~v.data;
            for (int i = 0; i < v.hold; i++) begin
                @(negedge clk);
                check("bp_rsp_valid", rsp_valid, 1);
                check("bp_rsp_data", rsp_data, v.exp_data);
                check("bp_rsp_err", rsp_err, v.exp_err);
                check("bp_cmd_ready", cmd_ready, 0);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("rsp_one_cycle", rsp_valid, 0);
        check("back_to_idle", cmd_ready, 1);
        check("txn_count", txn, exp_txn);
        check("o2c_holds", o2c, v.data);
        rsp_ready = 1'b0;
    endtask

    task automatic quick_txn(input logic [7:0] d);
        int k;
        @(negedge clk);
        cmd_data  = d;
        cmd_valid = 1'b1;
        en        = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("quick_txn_timeout", k, 2);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit saw_valid, saw_idle;
        logic [7:0] exp_txn;
        vec_t v;

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b0; en = 1'b0;
        cmd_valid3 = 1'b0; cmd_data3 = 8'h00; rsp_ready3 = 1'b0; en3 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_o2c", o2c, 8'h00);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_txn", txn, 8'h00);
        rst_n = 1'b1;

        //          data    en    hold exp_data err  cycles
        vecs[0] = '{8'hA5, 1'b1, 0,  8'hA5, 1'b0, 2};   // echo
        vecs[1] = '{8'h01, 1'b1, 0,  8'h01, 1'b0, 2};   // back-to-back
        vecs[2] = '{8'h02, 1'b1, 0,  8'h02, 1'b0, 2};
        vecs[3] = '{8'hFF, 1'b1, 0,  8'hFF, 1'b0, 2};
        vecs[4] = '{8'h3C, 1'b0, 0,  8'h00, 1'b1, 16};  // timeout
        vecs[5] = '{8'h5A, 1'b1, 10, 8'h5A, 1'b0, 2};   // backpressure

        exp_txn = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].exp_err) exp_txn = exp_txn + 8'd1;
            run_vec(vecs[i], exp_txn);
        end

        // Enable toggling every cycle: never completes, never times out.
        @(negedge clk);
        cmd_data = 8'h42; cmd_valid = 1'b1; en = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        saw_valid = 1'b0;
        saw_idle  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            en = ~en;
            @(negedge clk);
            if (rsp_valid) saw_valid = 1'b1;
            if (!busy) saw_idle = 1'b1;
        end
        check("toggle_no_rsp", saw_valid, 0);
        check("toggle_busy", saw_idle, 0);
        en = 1'b1;
        k = 0;
        while (!rsp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("toggle_recover_cycles", k, 2);
        check("toggle_recover_data", rsp_data, 8'h42);
        check("toggle_recover_err", rsp_err, 0);
        @(negedge clk);
        exp_txn = exp_txn + 8'd1;
        check("toggle_txn", txn, exp_txn);
        rsp_ready = 1'b0;

        // LATENCY=3 baseline, enable high throughout.
        @(negedge clk);
        cmd_data3 = 8'h11; cmd_valid3 = 1'b1; en3 = 1'b1; rsp_ready3 = 1'b1;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        k = 0;
        while (!rsp_valid3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("lat3_cycles", k, 4);
        check("lat3_data", rsp_data3, 8'h11);
        @(negedge clk);
        check("lat3_txn", txn3, 8'd1);

        // LATENCY=3 with a one-cycle enable drop during WAIT (sampled at the third edge).
        cmd_data3 = 8'h77; cmd_valid3 = 1'b1; en3 = 1'b1;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        k = 0;
        while (!rsp_valid3 && k < 100) begin
            en3 = (k == 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            k++;
        end
        check("drop_cycles", k, 7);
        check("drop_data", rsp_data3, 8'h77);
        check("drop_err", rsp_err3, 0);
        @(negedge clk);
        check("drop_txn", txn3, 8'd2);

        // Counter wrap after 256 successful transactions from reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            quick_txn(8'(i) ^ 8'h80);
            if (i == 254) check("txn_255", txn, 8'hFF);
        end
        check("txn_wrap", txn, 8'h00);
        check("wrap_last_data", rsp_data, 8'h7F);

        // Asynchronous reset while in WAIT.
        @(negedge clk);
        cmd_data = 8'hC3; cmd_valid = 1'b1; en = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_rst_o2c", o2c, 8'hC3);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_err", rsp_err, 0);
        check("mid_rst_o2c", o2c, 8'h00);
        check("mid_rst_rsp_data", rsp_data, 8'h00);
        check("mid_rst_txn", txn, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{8'h9E, 1'b1, 0, 8'h9E, 1'b0, 2};
        run_vec(v, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
